// File: rtl/filter_stage_sequencer.sv
// ---------------------------------------------------------------------------
// filter_stage_sequencer
//
// Sequences the enabled-register pipeline of the fixed-point filter datapath.
// For each accepted sample strobe it pulses, in order:
//   1. the input-register load enable,
//   2. one enable per pipeline stage, each on the last cycle of its settle
//      window,
//   3. the output-register enable together with a done pulse.
// A strobe that arrives while a computation is in flight is dropped and
// raises a sticky overrun flag.
//
// Every output is a flop loaded from the next-state decode, so there is no
// combinational path from any input to any output.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high reset
//   start_i      in   new-sample strobe
//   abort_i      in   synchronous abort of the current computation
//   clear_ovr_i  in   clears the sticky overrun flag
//   load_en_o    out  input sample register enable
//   stage_en_o   out  one-hot stage register enables (NUM_STAGES bits)
//   out_en_o     out  output register enable
//   done_o       out  one-cycle pulse, coincident with out_en_o
//   busy_o       out  high while loading or walking the stages
//   overrun_o    out  sticky: start seen while busy
//   stage_idx_o  out  current stage index, 0 outside the stage walk
//   sample_cnt_o out  count of completed samples (wraps)
// ---------------------------------------------------------------------------
module filter_stage_sequencer #(
  parameter int NUM_STAGES   = 9,
  parameter int STAGE_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic                          clear_ovr_i,
  output logic                          load_en_o,
  output logic [NUM_STAGES-1:0]         stage_en_o,
  output logic                          out_en_o,
  output logic                          done_o,
  output logic                          busy_o,
  output logic                          overrun_o,
  output logic [$clog2(NUM_STAGES):0]   stage_idx_o,
  output logic [CNT_W-1:0]              sample_cnt_o
);

  localparam int IW = $clog2(NUM_STAGES) + 1;
  // A one-cycle window still needs a 1-bit counter to keep the logic uniform.
  localparam int CW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam logic [CW-1:0] WIN_LAST = CW'(STAGE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STAGE  = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         win_q, win_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovr_q, ovr_d;
  logic [NUM_STAGES-1:0] stage_en_d;

  // Next-state, window/stage counters and completed-sample counter.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // abort in the same cycle as start drops the strobe
        if (start_i && !abort_i) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        win_d = {CW{1'b0}};
        idx_d = {IW{1'b0}};
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_STAGE;
        end
      end
      S_STAGE: begin
        if (abort_i) begin
          state_d = S_IDLE;
          win_d   = {CW{1'b0}};
          idx_d   = {IW{1'b0}};
        end else if (win_q == WIN_LAST) begin
          win_d = {CW{1'b0}};
          if (idx_q == IDX_LAST) begin
            // Count the sample as completed when the output cycle is entered,
            // so the count is already updated alongside done.
            state_d = S_OUTPUT;
            idx_d   = {IW{1'b0}};
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          win_d = win_q + CW'(1);
        end
      end
      S_OUTPUT: begin
        // Back-to-back start goes straight to LOAD; abort overrides it.
        if (start_i && !abort_i) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        win_d   = {CW{1'b0}};
        idx_d   = {IW{1'b0}};
      end
    endcase
  end

  // Sticky overrun: a set request in the same cycle beats clear.
  always_comb begin
    if (((state_q == S_LOAD) || (state_q == S_STAGE)) && start_i) begin
      ovr_d = 1'b1;
    end else if (clear_ovr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Stage enable for the upcoming cycle: only the last window cycle fires.
  always_comb begin
    stage_en_d = {NUM_STAGES{1'b0}};
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_en_d[i] = (state_d == S_STAGE) && (win_d == WIN_LAST) &&
                      (idx_d == IW'(i));
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      win_q      <= {CW{1'b0}};
      idx_q      <= {IW{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      ovr_q      <= 1'b0;
      load_en_o  <= 1'b0;
      stage_en_o <= {NUM_STAGES{1'b0}};
      out_en_o   <= 1'b0;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ovr_q      <= ovr_d;
      load_en_o  <= (state_d == S_LOAD);
      stage_en_o <= stage_en_d;
      out_en_o   <= (state_d == S_OUTPUT);
      done_o     <= (state_d == S_OUTPUT);
      busy_o     <= (state_d == S_LOAD) || (state_d == S_STAGE);
    end
  end

  // idx_q is held at zero outside the stage walk, so it doubles as the index.
  assign stage_idx_o  = idx_q;
  assign sample_cnt_o = cnt_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_filter_stage_sequencer.sv
// Directed bench for filter_stage_sequencer: a default-parameter instance
// (9 stages, 2-cycle windows) and a small instance (3 stages, 1-cycle
// windows, 2-bit sample counter) sharing clock and reset.
module tb_filter_stage_sequencer;

  logic clk;
  logic reset;

  // default instance
  logic       start_a, abort_a, clr_a;
  logic       load_a, out_a, done_a, busy_a, ovr_a;
  logic [8:0] stage_a;
  logic [4:0] idx_a;
  logic [15:0] cnt_a;

  // small instance
  logic       start_b, abort_b, clr_b;
  logic       load_b, out_b, done_b, busy_b, ovr_b;
  logic [2:0] stage_b;
  logic [2:0] idx_b;
  logic [1:0] cnt_b;

  int vectors;
  int miscompares;

  filter_stage_sequencer dut_a (
    .clk(clk), .reset(reset),
    .start_i(start_a), .abort_i(abort_a), .clear_ovr_i(clr_a),
    .load_en_o(load_a), .stage_en_o(stage_a), .out_en_o(out_a),
    .done_o(done_a), .busy_o(busy_a), .overrun_o(ovr_a),
    .stage_idx_o(idx_a), .sample_cnt_o(cnt_a)
  );

  filter_stage_sequencer #(.NUM_STAGES(3), .STAGE_CYCLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset),
    .start_i(start_b), .abort_i(abort_b), .clear_ovr_i(clr_b),
    .load_en_o(load_b), .stage_en_o(stage_b), .out_en_o(out_b),
    .done_o(done_b), .busy_o(busy_b), .overrun_o(ovr_b),
    .stage_idx_o(idx_b), .sample_cnt_o(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected default-instance strobes at 'rel' cycles after the start cycle;
  // rel outside 1..20 means idle.
  task automatic check_a(input string tag, input int rel);
    logic [8:0] es;
    logic [4:0] ei;
    es = 9'd0;
    for (int i = 0; i < 9; i++) begin
      if (rel == 1 + (i + 1) * 2) es[i] = 1'b1;
    end
    ei = (rel >= 2 && rel <= 19) ? 5'((rel - 2) / 2) : 5'd0;
    chk(tag, {14'd0, load_a, stage_a, out_a, done_a, busy_a, idx_a},
             {14'd0, (rel == 1), es, (rel == 20), (rel == 20),
              (rel >= 1 && rel <= 19), ei});
  endtask

  // Expected small-instance strobes; rel 1..5 within a sample, else idle.
  task automatic check_b(input string tag, input int rel);
    logic [2:0] es;
    logic [2:0] ei;
    es = 3'd0;
    ei = 3'd0;
    if (rel >= 2 && rel <= 4) begin
      es[rel - 2] = 1'b1;
      ei = 3'(rel - 2);
    end
    chk(tag, {22'd0, load_b, stage_b, out_b, done_b, busy_b, idx_b},
             {22'd0, (rel == 1), es, (rel == 5), (rel == 5),
              (rel >= 1 && rel <= 4), ei});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset   = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; clr_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; clr_b = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_a("reset_a", 0);
    chk("reset_ovr_a", {31'd0, ovr_a}, 32'd0);
    chk("reset_cnt_a", {16'd0, cnt_a}, 32'd0);
    check_b("reset_b", 0);
    @(negedge clk) reset = 1'b0;
    step();

    // single sample
    start_a = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      start_a = 1'b0;
      check_a($sformatf("single_c%0d", c), c);
    end
    chk("single_cnt", {16'd0, cnt_a}, 32'd1);

    // back-to-back: start held during OUTPUT
    start_a = 1'b1;
    for (int c = 1; c <= 41; c++) begin
      step();
      start_a = (c == 20);
      check_a($sformatf("b2b_c%0d", c), (c <= 20) ? c : c - 20);
    end
    chk("b2b_cnt", {16'd0, cnt_a}, 32'd3);
    chk("b2b_ovr", {31'd0, ovr_a}, 32'd0);

    // overrun set / clear / set-beats-clear
    start_a = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      step();
      start_a = (c == 7) || (c == 26) || (c == 28) || (c == 29);
      clr_a   = (c == 25) || (c == 29) || (c == 30);
      abort_a = (c == 31);
      if (c <= 21)      check_a($sformatf("ovr_c%0d", c), c);
      else if (c <= 26) check_a($sformatf("ovr_c%0d", c), 0);
      else if (c <= 31) check_a($sformatf("ovr_c%0d", c), c - 26);
      else              check_a($sformatf("ovr_c%0d", c), 0);
      chk($sformatf("ovr_flag_c%0d", c), {31'd0, ovr_a},
          {31'd0, ((c >= 8 && c <= 25) || c == 29 || c == 30)});
    end
    abort_a = 1'b0;
    chk("ovr_cnt", {16'd0, cnt_a}, 32'd4);

    // abort mid-sequence, then fresh start
    start_a = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      step();
      start_a = (c == 15);
      abort_a = (c == 10);
      check_a($sformatf("abort_c%0d", c), (c <= 10) ? c : ((c <= 15) ? 0 : c - 15));
    end
    chk("abort_cnt", {16'd0, cnt_a}, 32'd5);
    chk("abort_ovr", {31'd0, ovr_a}, 32'd0);

    // abort+start in IDLE, then abort+start in OUTPUT
    start_a = 1'b1;
    abort_a = 1'b1;
    step();
    start_a = 1'b0;
    abort_a = 1'b0;
    check_a("idle_abort_start", 0);
    start_a = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      start_a = (c == 20);
      abort_a = (c == 20);
      check_a($sformatf("out_abort_c%0d", c), c);
    end
    abort_a = 1'b0;
    chk("out_abort_ovr", {31'd0, ovr_a}, 32'd0);
    chk("out_abort_cnt", {16'd0, cnt_a}, 32'd6);

    // async reset mid-sequence with overrun set
    start_a = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      start_a = (c == 5);
      check_a($sformatf("rst_pre_c%0d", c), c);
    end
    chk("rst_pre_ovr", {31'd0, ovr_a}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_a("rst_async", 0);
    chk("rst_async_ovr", {31'd0, ovr_a}, 32'd0);
    chk("rst_async_cnt", {16'd0, cnt_a}, 32'd0);
    @(negedge clk) reset = 1'b0;
    step();
    start_a = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      start_a = 1'b0;
      check_a($sformatf("rst_post_c%0d", c), c);
    end
    chk("rst_post_cnt", {16'd0, cnt_a}, 32'd1);

    // small instance: one-cycle windows, four samples wrap the 2-bit count
    start_b = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      start_b = (c == 5) || (c == 10) || (c == 15);
      check_b($sformatf("b_c%0d", c), (c <= 20) ? ((c - 1) % 5) + 1 : 0);
      if (c == 6)  chk("b_cnt1", {30'd0, cnt_b}, 32'd1);
      if (c == 11) chk("b_cnt2", {30'd0, cnt_b}, 32'd2);
      if (c == 16) chk("b_cnt3", {30'd0, cnt_b}, 32'd3);
    end
    chk("b_cnt_wrap", {30'd0, cnt_b}, 32'd0);
    chk("b_ovr", {31'd0, ovr_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
